aes_core_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_sbox_mux.sv | 34 +++
 rtl/aes_core_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_core_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 core sequencer: widths, controller
// state encoding, the command-reject flag value and the S-box ownership rule.
package aes_pkg;

    // Block and key width, fixed by AES-128.
    localparam int unsigned BLOCK_W = 128;
    // Width of the single shared S-box word path (four bytes).
    localparam int unsigned SBOX_W  = 32;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_START = 3'd1,
        KEY_WAIT  = 3'd2,
        ENC_START = 3'd3,
        ENC_WAIT  = 3'd4
    } state_e;

    // Level driven on cmdErr for the single cycle after a rejected command.
    localparam logic CMD_ERR = 1'b1;

    // Key expansion owns the S-box for its whole start/wait window; the
    // encryption datapath owns it in every other state.
    function automatic logic key_owns_sbox(input state_e s);
        return (s == KEY_START) || (s == KEY_WAIT);
    endfunction

endpackage

// File: rtl/aes_sbox_mux.sv
// Combinational ownership routing of the shared S-box word unit.
// Ports:
//   state      controller state, selects the current S-box owner
//   keySubIn   word from key expansion to substitute
//   encSubIn   word from the encryption block to substitute
//   sboxOut    substituted word from the shared S-box unit
//   sboxIn     word presented to the shared S-box unit
//   keySubOut  substituted word back to key expansion (0 when not owner)
//   encSubOut  substituted word back to encryption (0 when not owner)
module aes_sbox_mux
    import aes_pkg::*;
(
    input  state_e            state,
    input  logic [SBOX_W-1:0] keySubIn,
    input  logic [SBOX_W-1:0] encSubIn,
    input  logic [SBOX_W-1:0] sboxOut,
    output logic [SBOX_W-1:0] sboxIn,
    output logic [SBOX_W-1:0] keySubOut,
    output logic [SBOX_W-1:0] encSubOut
);

    // Exactly one requester sees the S-box; the other gets zeros.
    always_comb begin
        sboxIn    = encSubIn;
        keySubOut = '0;
        encSubOut = sboxOut;
        if (key_owns_sbox(state)) begin
            sboxIn    = keySubIn;
            keySubOut = sboxOut;
            encSubOut = '0;
        end
    end

endmodule

// File: rtl/aes_core_ctrl.sv
// Top-level sequencer for the AES-128 core: accepts host init/next commands,
// starts key expansion or block encryption, latches the ciphertext and owns
// the routing of the shared S-box word unit.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   init, next           host command pulses (expand key / encrypt block)
//   key, block           host key and plaintext, consumed by the sub-blocks
//   ready                controller idle, can accept a command
//   keyValid             expanded key present
//   result, resultValid  last ciphertext and its validity
//   cmdErr               one-cycle pulse on a rejected command
//   keyInit, keyReady    key expansion start pulse / idle-done flag
//   keySubIn, keySubOut  key expansion S-box request/response
//   encNext, encReady    encryption start pulse / idle-done flag
//   encBlock             encryption block output
//   encSubIn, encSubOut  encryption S-box request/response
//   sboxIn, sboxOut      shared S-box unit (combinational, same cycle)
module aes_core_ctrl
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               next,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] block,
    output logic               ready,
    output logic               keyValid,
    output logic [BLOCK_W-1:0] result,
    output logic               resultValid,
    output logic               cmdErr,
    output logic               keyInit,
    input  logic               keyReady,
    input  logic [SBOX_W-1:0]  keySubIn,
    output logic [SBOX_W-1:0]  keySubOut,
    output logic               encNext,
    input  logic               encReady,
    input  logic [BLOCK_W-1:0] encBlock,
    input  logic [SBOX_W-1:0]  encSubIn,
    output logic [SBOX_W-1:0]  encSubOut,
    output logic [SBOX_W-1:0]  sboxIn,
    input  logic [SBOX_W-1:0]  sboxOut
);

    state_e state;

    // key and block go straight to the sub-blocks; the controller only
    // carries them on its boundary so the core has one host-facing port list.
    logic unused_host_data;
    assign unused_host_data = ^{key, block};

    // Sequencer. Start pulses are raised on the accepting edge so they are
    // high during the *_START cycle, one cycle after the command edge. The
    // sub-block ready flag drops on the edge that samples the pulse, so the
    // *_WAIT states never observe a stale ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            keyValid    <= 1'b0;
            result      <= '0;
            resultValid <= 1'b0;
            cmdErr      <= 1'b0;
            keyInit     <= 1'b0;
            encNext     <= 1'b0;
        end else begin
            cmdErr  <= 1'b0;
            keyInit <= 1'b0;
            encNext <= 1'b0;

            // Any command while busy is dropped and flagged.
            if ((state != IDLE) && (init || next)) begin
                cmdErr <= CMD_ERR;
            end

            case (state)
                IDLE: begin
                    if (init) begin
                        // init wins over a simultaneous next, silently.
                        state       <= KEY_START;
                        ready       <= 1'b0;
                        keyValid    <= 1'b0;
                        resultValid <= 1'b0;
                        keyInit     <= 1'b1;
                    end else if (next) begin
                        if (keyValid) begin
                            state       <= ENC_START;
                            ready       <= 1'b0;
                            resultValid <= 1'b0;
                            encNext     <= 1'b1;
                        end else begin
                            cmdErr <= CMD_ERR;
                        end
                    end
                end

                KEY_START: begin
                    state <= KEY_WAIT;
                end

                KEY_WAIT: begin
                    if (keyReady) begin
                        state    <= IDLE;
                        keyValid <= 1'b1;
                        ready    <= 1'b1;
                    end
                end

                ENC_START: begin
                    state <= ENC_WAIT;
                end

                ENC_WAIT: begin
                    if (encReady) begin
                        state       <= IDLE;
                        result      <= encBlock;
                        resultValid <= 1'b1;
                        ready       <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Shared S-box ownership follows the controller state.
    aes_sbox_mux u_sbox_mux (
        .state     (state),
        .keySubIn  (keySubIn),
        .encSubIn  (encSubIn),
        .sboxOut   (sboxOut),
        .sboxIn    (sboxIn),
        .keySubOut (keySubOut),
        .encSubOut (encSubOut)
    );

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Self-checking bench for aes_core_ctrl: stub key-expansion, encryption and
// S-box units, a transaction-level reference model that pushes expected
// command events into queues, and a negedge monitor that pops and compares.
module tb_aes_core_ctrl;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         init = 1'b0;
    logic         next = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] block = '0;
    logic         ready, keyValid, resultValid, cmdErr, keyInit, encNext;
    logic [127:0] result;
    logic         keyReady, encReady;
    logic [127:0] encBlock;
    logic [31:0]  keySubIn = '0, encSubIn = '0;
    logic [31:0]  keySubOut, encSubOut, sboxIn, sboxOut;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    aes_core_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .next        (next),
        .key         (key),
        .block       (block),
        .ready       (ready),
        .keyValid    (keyValid),
        .result      (result),
        .resultValid (resultValid),
        .cmdErr      (cmdErr),
        .keyInit     (keyInit),
        .keyReady    (keyReady),
        .keySubIn    (keySubIn),
        .keySubOut   (keySubOut),
        .encNext     (encNext),
        .encReady    (encReady),
        .encBlock    (encBlock),
        .encSubIn    (encSubIn),
        .encSubOut   (encSubOut),
        .sboxIn      (sboxIn),
        .sboxOut     (sboxOut)
    );

    // Known-answer encryptor: the FIPS-197 vector, otherwise a keyed mix.
    function automatic logic [127:0] enc_f(input logic [127:0] k, input logic [127:0] b);
        if (k == FIPS_K && b == FIPS_P) return FIPS_C;
        return {b[63:0], b[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_c3c3_a5a5_f0f0_1234_8765;
    endfunction

    function automatic logic [31:0] sbox_f(input logic [31:0] x);
        return {x[23:0], x[31:24]} ^ 32'h6363_6363;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stub sub-blocks ----------------
    int           key_lat = 2, enc_lat = 3;
    int           kcnt, ecnt;
    logic [127:0] stub_key, stub_blk;

    assign sboxOut = sbox_f(sboxIn);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyReady <= 1'b1; kcnt <= 0; stub_key <= '0;
        end else if (keyInit) begin
            keyReady <= 1'b0; kcnt <= key_lat; stub_key <= key;
        end else if (!keyReady) begin
            if (kcnt == 0) keyReady <= 1'b1;
            else kcnt <= kcnt - 1;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            encReady <= 1'b1; ecnt <= 0; stub_blk <= '0; encBlock <= '0;
        end else if (encNext) begin
            encReady <= 1'b0; ecnt <= enc_lat; stub_blk <= block;
        end else if (!encReady) begin
            if (ecnt == 0) begin
                encReady <= 1'b1;
                encBlock <= enc_f(stub_key, stub_blk);
            end else begin
                ecnt <= ecnt - 1;
            end
        end
    end

    // ---------------- reference model ----------------
    // Host-level view: a command is accepted only when no operation is in
    // flight; an operation ends when its sub-block has gone busy and returned.
    logic         m_key, m_enc, m_kv, m_rv, m_kseen, m_eseen;
    logic [127:0] m_kval, m_res, m_pend;
    int           kinit_q[$], encn_q[$], err_q[$];
    logic         m_idle;
    assign m_idle = !m_key && !m_enc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_key <= 1'b0; m_enc <= 1'b0; m_kv <= 1'b0; m_rv <= 1'b0;
            m_kseen <= 1'b0; m_eseen <= 1'b0;
            m_kval <= '0; m_res <= '0; m_pend <= '0;
            kinit_q.delete(); encn_q.delete(); err_q.delete();
        end else if (m_idle) begin
            if (init) begin
                m_key <= 1'b1; m_kv <= 1'b0; m_rv <= 1'b0; m_kseen <= 1'b0;
                m_kval <= key;
                kinit_q.push_back(1);
            end else if (next) begin
                if (m_kv) begin
                    m_enc <= 1'b1; m_rv <= 1'b0; m_eseen <= 1'b0;
                    m_pend <= enc_f(m_kval, block);
                    encn_q.push_back(1);
                end else begin
                    err_q.push_back(1);
                end
            end
        end else begin
            if (init || next) err_q.push_back(1);
            if (m_key) begin
                if (!keyReady) m_kseen <= 1'b1;
                else if (m_kseen) begin m_key <= 1'b0; m_kv <= 1'b1; end
            end
            if (m_enc) begin
                if (!encReady) m_eseen <= 1'b1;
                else if (m_eseen) begin m_enc <= 1'b0; m_rv <= 1'b1; m_res <= m_pend; end
            end
        end
    end

    // ---------------- monitor ----------------
    logic mon_en = 1'b0;
    int   n_kinit = 0, n_encn = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready", 128'(ready), 128'(m_idle));
            chk("keyValid", 128'(keyValid), 128'(m_kv));
            chk("resultValid", 128'(resultValid), 128'(m_rv));
            chk("result", result, m_res);
            chk("sboxIn", 128'(sboxIn), 128'(m_key ? keySubIn : encSubIn));
            chk("keySubOut", 128'(keySubOut), 128'(m_key ? sbox_f(keySubIn) : 32'h0));
            chk("encSubOut", 128'(encSubOut), 128'(m_key ? 32'h0 : sbox_f(encSubIn)));
            if (keyInit) begin
                n_kinit++;
                if (kinit_q.size() == 0) chk("keyInit_unexpected", 128'(keyInit), 128'(0));
                else void'(kinit_q.pop_front());
            end
            if (encNext) begin
                n_encn++;
                if (encn_q.size() == 0) chk("encNext_unexpected", 128'(encNext), 128'(0));
                else void'(encn_q.pop_front());
            end
            if (cmdErr) begin
                if (err_q.size() == 0) chk("cmdErr_unexpected", 128'(cmdErr), 128'(0));
                else void'(err_q.pop_front());
            end
            chk("keyInit_missing", 128'(kinit_q.size()), 128'(0));
            chk("encNext_missing", 128'(encn_q.size()), 128'(0));
            chk("cmdErr_missing", 128'(err_q.size()), 128'(0));
        end
    end

    // ---------------- sub-block S-box requests ----------------
    logic sub_fixed = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (sub_fixed) begin
                keySubIn = 32'hAAAA_0000;
                encSubIn = 32'h5555_FFFF;
            end else begin
                keySubIn = $urandom;
                encSubIn = $urandom;
            end
        end
    end

    // ---------------- driver ----------------
    // Host data only changes when a command could be accepted, so key/block
    // stay stable across any operation in flight.
    task automatic cmd(input logic di, input logic dn, input logic [127:0] k, input logic [127:0] b);
        @(posedge clk); #1;
        if (m_idle) begin key = k; block = b; end
        init = di; next = dn;
        @(posedge clk); #1;
        init = 1'b0; next = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_idle && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_timeout", 128'(m_idle), 128'(1));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_keyValid", 128'(keyValid), 128'(0));
        chk("rst_resultValid", 128'(resultValid), 128'(0));
        chk("rst_result", result, 128'(0));
        chk("rst_cmdErr", 128'(cmdErr), 128'(0));
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    initial begin
        int k0, e0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_keyValid", 128'(keyValid), 128'(0));
        chk("reset_result", result, 128'(0));
        chk("reset_keyInit", 128'(keyInit), 128'(0));
        reset = 1'b1;

        // next with no key: one-cycle cmdErr, no encNext
        e0 = n_encn;
        cmd(1'b0, 1'b1, FIPS_K, FIPS_P);
        repeat (3) @(posedge clk);
        chk("nokey_encNext", 128'(n_encn - e0), 128'(0));
        chk("nokey_ready", 128'(ready), 128'(1));

        // FIPS-197 vector with fixed sub-block words
        sub_fixed = 1'b1;
        cmd(1'b1, 1'b0, FIPS_K, FIPS_P);
        wait_idle();
        @(negedge clk);
        chk("fips_keyValid", 128'(keyValid), 128'(1));
        cmd(1'b0, 1'b1, FIPS_K, FIPS_P);
        wait_idle();
        @(negedge clk);
        chk("fips_resultValid", 128'(resultValid), 128'(1));
        chk("fips_result", result, FIPS_C);

        // init and next together: init wins
        k0 = n_kinit; e0 = n_encn;
        cmd(1'b1, 1'b1, 128'hfeed_0001, 128'hbeef_0002);
        wait_idle();
        repeat (2) @(posedge clk);
        chk("same_cycle_keyInit", 128'(n_kinit - k0), 128'(1));
        chk("same_cycle_encNext", 128'(n_encn - e0), 128'(0));

        // second next while in ENC_WAIT is rejected
        enc_lat = 6;
        e0 = n_encn;
        cmd(1'b0, 1'b1, 128'hfeed_0001, 128'h0123_4567_89ab_cdef);
        @(posedge clk); #1;
        cmd(1'b0, 1'b1, 128'hfeed_0001, 128'hdead_dead);
        wait_idle();
        @(negedge clk);
        chk("busy_next_encNext", 128'(n_encn - e0), 128'(1));
        chk("busy_next_result", result, enc_f(128'hfeed_0001, 128'h0123_4567_89ab_cdef));
        sub_fixed = 1'b0;

        // reset during ENC_WAIT, then next needs a fresh key
        cmd(1'b0, 1'b1, 128'hfeed_0001, 128'h7777);
        @(posedge clk);
        pulse_reset();
        cmd(1'b0, 1'b1, 128'hfeed_0001, 128'h8888);
        repeat (2) @(posedge clk);

        // randomized command traffic
        for (int i = 0; i < 300; i++) begin
            key_lat = $urandom_range(0, 5);
            enc_lat = $urandom_range(0, 5);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                cmd(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 5),
                    {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom});
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
